// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, block width, GF(2^8) helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  localparam int BLOCK_W = 128;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column {a0,a1,a2,a3}, a0 = row 0 in the MSB byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_enc_iterative.sv
// Iterative AES encryptor: one round per clock, one block in flight,
// valid/ready on both sides. Define AES_ENC_KEY_LATCH_EN to capture the
// round-key schedule at accept so upstream may change it mid-operation.
module aes_enc_iterative
  import aes_pkg::*;
#(
  parameter int ROUNDS = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:127]                  plaintext,
  input  logic [0:128*(ROUNDS+1)-1]     round_keys,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:127]                  ciphertext
);

  localparam int RND_W  = $clog2(ROUNDS + 1);
  localparam int KEYS_W = BLOCK_W * (ROUNDS + 1);

  aes_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] blk_q, blk_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               last_rnd;
  logic [0:KEYS_W-1]  keys;
  logic [BLOCK_W-1:0] rk_cur, sb, sr, mc, rnd_out;

  assign accept   = (state_q == IDLE) && in_valid && in_ready_q;
  assign last_rnd = (rnd_q == RND_W'(ROUNDS));

`ifdef AES_ENC_KEY_LATCH_EN
  logic [0:KEYS_W-1] key_q, key_d;

  // Capture the whole schedule on the accept edge.
  always_comb key_d = accept ? round_keys : key_q;

  // Key register.
  always_ff @(posedge clk) begin
    if (rst) key_q <= '0;
    else     key_q <= key_d;
  end

  assign keys = key_q;
`else
  assign keys = round_keys;
`endif

  // Select round key [rnd]; round 0 is applied from round_keys at accept.
  always_comb begin
    rk_cur = '0;
    for (int r = 0; r <= ROUNDS; r++)
      if (rnd_q == RND_W'(r)) rk_cur = keys[BLOCK_W*r +: BLOCK_W];
  end

  // SubBytes: byte i lives at bits [127-8i -: 8].
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (blk_q[127-8*i -: 8]),
      .out_byte (sb[127-8*i -: 8])
    );
  end

  // ShiftRows: row r of column c takes row r of column (c+r) mod 4.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
  end

  // MixColumns per column, then AddRoundKey; final round skips MixColumns.
  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    rnd_out = (last_rnd ? sr : mc) ^ rk_cur;
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequencer.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    ct_d        = ct_q;
    rnd_d       = rnd_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          blk_d      = plaintext ^ round_keys[0:127];
          rnd_d      = RND_W'(1);
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        blk_d = rnd_out;
        if (last_rnd) begin
          ct_d        = rnd_out;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          rnd_d = rnd_q + RND_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          rnd_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      ct_q        <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      ct_q        <= ct_d;
      rnd_q       <= rnd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;

endmodule
